mem_stage_ctrl: RTL and testbench

- MEM pipeline stage directly downstream of the EX/MEM register.
- Consumes the EX/MEM fields and runs a req/ready handshake with a variable-latency data memory.
- Stalls upstream while an access is outstanding, selects write-back data, and registers the MEM/WB outputs.
- Also provides the MEM/WB forwarding source and the sticky halt/error indications.

---
 rtl/mem_stage_ctrl_pkg.sv | 26 ++
 rtl/mem_stage_ctrl_mem_wb_reg.sv | 50 +++++
 rtl/mem_stage_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types and defaults for the MEM stage controller and its MEM/WB register bank.
package mem_stage_ctrl_pkg;

  localparam int DW_DEF       = 16;
  localparam int RW_DEF       = 4;
  localparam int MAX_WAIT_DEF = 15;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    WB_SEL_MEM = 2'd0,
    WB_SEL_PC  = 2'd1,
    WB_SEL_ALU = 2'd2
  } wb_sel_e;

  // Memory data wins over the link value when both are flagged.
  function automatic wb_sel_e wb_sel(input logic memtoreg, input logic pcs);
    if (memtoreg) return WB_SEL_MEM;
    if (pcs)      return WB_SEL_PC;
    return WB_SEL_ALU;
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_mem_wb_reg.sv
// MEM/WB pipeline register bank: a load pulse captures a completing instruction,
// otherwise a bubble is inserted (valid/we/hlt cleared, rd/data held).
module dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= d;
  end
endmodule

module mem_wb_reg
  import mem_stage_ctrl_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic          we_i,
  input  logic          hlt_i,
  input  logic [RW-1:0] rd_i,
  input  logic [DW-1:0] data_i,
  output logic          valid_o,
  output logic          we_o,
  output logic          hlt_o,
  output logic [RW-1:0] rd_o,
  output logic [DW-1:0] data_o
);
  logic          we_d, hlt_d;
  logic [RW-1:0] rd_d;
  logic [DW-1:0] data_d;

  assign we_d   = load_i & we_i;
  assign hlt_d  = load_i & hlt_i;
  assign rd_d   = load_i ? rd_i : rd_o;
  assign data_d = load_i ? data_i : data_o;

  dff #(.W(1))  u_valid (.clk(clk), .rst_n(rst_n), .d(load_i), .q(valid_o));
  dff #(.W(1))  u_we    (.clk(clk), .rst_n(rst_n), .d(we_d),   .q(we_o));
  dff #(.W(1))  u_hlt   (.clk(clk), .rst_n(rst_n), .d(hlt_d),  .q(hlt_o));
  dff #(.W(RW)) u_rd    (.clk(clk), .rst_n(rst_n), .d(rd_d),   .q(rd_o));
  dff #(.W(DW)) u_data  (.clk(clk), .rst_n(rst_n), .d(data_d), .q(data_o));
endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage: req/ready handshake with a variable-latency data memory,
// upstream stall, write-back select, MEM/WB register, sticky halt and timeout error.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int RW       = RW_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_memread,
  input  logic          in_memwrite,
  input  logic          in_memtoreg,
  input  logic          in_pcs,
  input  logic          in_writereg,
  input  logic          in_hlt,
  input  logic [RW-1:0] in_rd,
  input  logic [DW-1:0] in_alu,
  input  logic [DW-1:0] in_wdata,
  input  logic [DW-1:0] in_pc,
  output logic          stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          wb_valid,
  output logic          wb_we,
  output logic [RW-1:0] wb_rd,
  output logic [DW-1:0] wb_data,
  output logic          wb_hlt,
  output logic          halted,
  output logic          mem_err
);
  localparam int CW = $clog2(MAX_WAIT + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          halted_q, halted_d, mem_err_q, mem_err_d;
  logic          latch_en;

  logic [DW-1:0] addr_q, wdata_q, pc_q;
  logic [RW-1:0] rd_q;
  logic          we_q, memtoreg_q, pcs_q, writereg_q, hlt_q;

  logic          acc, cmp_load, cmp_abort, cmp_we;
  logic          c_memtoreg, c_pcs, c_writereg, c_store, c_hlt;
  logic [RW-1:0] c_rd;
  logic [DW-1:0] c_pc, c_alu, c_data;

  // rst gates acc so the request and its strobes drop with reset, not on a clock.
  assign acc = rst & in_valid & (in_memread | in_memwrite) & ~halted_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_err_d  = mem_err_q;
    latch_en   = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = in_alu;
    mem_wdata  = in_wdata;
    stall      = 1'b0;
    cmp_load   = 1'b0;
    cmp_abort  = 1'b0;
    c_rd       = in_rd;
    c_memtoreg = in_memtoreg;
    c_pcs      = in_pcs;
    c_writereg = in_writereg;
    c_store    = in_memwrite;
    c_hlt      = in_hlt;
    c_pc       = in_pc;
    c_alu      = in_alu;
    case (state_q)
      IDLE: begin
        if (acc) begin
          mem_req = 1'b1;
          mem_we  = in_memwrite;
          if (mem_ready) begin
            cmp_load = 1'b1;
          end else begin
            stall    = 1'b1;
            latch_en = 1'b1;
            cnt_d    = '0;
            state_d  = BUSY;
          end
        end else if (rst && in_valid && !halted_q) begin
          cmp_load = 1'b1;
        end
      end
      BUSY: begin
        mem_req    = 1'b1;
        mem_we     = we_q;
        mem_addr   = addr_q;
        mem_wdata  = wdata_q;
        c_rd       = rd_q;
        c_memtoreg = memtoreg_q;
        c_pcs      = pcs_q;
        c_writereg = writereg_q;
        c_store    = we_q;
        c_hlt      = hlt_q;
        c_pc       = pc_q;
        c_alu      = addr_q;
        if (mem_ready) begin
          cmp_load = 1'b1;
          state_d  = IDLE;
        end else if (cnt_q == CW'(MAX_WAIT - 1)) begin
          // Abort retires the instruction without stalling so it is not reissued.
          cmp_load  = 1'b1;
          cmp_abort = 1'b1;
          mem_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    case (wb_sel(c_memtoreg, c_pcs))
      WB_SEL_MEM: c_data = mem_rdata;
      WB_SEL_PC:  c_data = c_pc;
      default:    c_data = c_alu;
    endcase
    cmp_we   = c_writereg & (c_rd != '0) & ~c_store & ~cmp_abort;
    halted_d = halted_q | (cmp_load & c_hlt);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      halted_q   <= 1'b0;
      mem_err_q  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      pc_q       <= '0;
      rd_q       <= '0;
      we_q       <= 1'b0;
      memtoreg_q <= 1'b0;
      pcs_q      <= 1'b0;
      writereg_q <= 1'b0;
      hlt_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      halted_q  <= halted_d;
      mem_err_q <= mem_err_d;
      if (latch_en) begin
        addr_q     <= in_alu;
        wdata_q    <= in_wdata;
        pc_q       <= in_pc;
        rd_q       <= in_rd;
        we_q       <= in_memwrite;
        memtoreg_q <= in_memtoreg;
        pcs_q      <= in_pcs;
        writereg_q <= in_writereg;
        hlt_q      <= in_hlt;
      end
    end
  end

  mem_wb_reg #(.DW(DW), .RW(RW)) u_mem_wb (
    .clk     (clk),
    .rst_n   (rst),
    .load_i  (cmp_load),
    .we_i    (cmp_we),
    .hlt_i   (c_hlt),
    .rd_i    (c_rd),
    .data_i  (c_data),
    .valid_o (wb_valid),
    .we_o    (wb_we),
    .hlt_o   (wb_hlt),
    .rd_o    (wb_rd),
    .data_o  (wb_data)
  );

  assign halted  = halted_q;
  assign mem_err = mem_err_q;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: inputs change 1ns after the rising edge,
// combinational outputs are sampled mid-cycle, registered outputs 1ns after the edge.
module tb_mem_stage_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid, in_memread, in_memwrite, in_memtoreg, in_pcs, in_writereg, in_hlt;
  logic [3:0]  in_rd;
  logic [15:0] in_alu, in_wdata, in_pc;
  logic        stall, mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;
  logic        wb_valid, wb_we, wb_hlt, halted, mem_err;
  logic [3:0]  wb_rd;
  logic [15:0] wb_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_memread(in_memread), .in_memwrite(in_memwrite),
    .in_memtoreg(in_memtoreg), .in_pcs(in_pcs), .in_writereg(in_writereg), .in_hlt(in_hlt),
    .in_rd(in_rd), .in_alu(in_alu), .in_wdata(in_wdata), .in_pc(in_pc),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_hlt(wb_hlt), .halted(halted), .mem_err(mem_err)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clr();
    in_valid = 0; in_memread = 0; in_memwrite = 0; in_memtoreg = 0;
    in_pcs = 0; in_writereg = 0; in_hlt = 0; in_rd = '0;
    in_alu = '0; in_wdata = '0; in_pc = '0; mem_ready = 0; mem_rdata = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_in(input logic [3:0] rd, input logic [15:0] alu);
    clr();
    in_valid = 1; in_memread = 1; in_memtoreg = 1; in_writereg = 1;
    in_rd = rd; in_alu = alu;
  endtask

  int  stall_cnt;
  bit  aborted;

  initial begin
    clr();
    #2 rst = 0;
    #1;
    check("rst_wb_valid", 32'(wb_valid), 0);
    check("rst_wb_we", 32'(wb_we), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_mem_err", 32'(mem_err), 0);
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_stall", 32'(stall), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1;

    // reset while a load waits
    load_in(4'd2, 16'h0080);
    #4;
    check("rb_issue_stall", 32'(stall), 1);
    check("rb_issue_req", 32'(mem_req), 1);
    tick();
    #4;
    check("rb_busy_stall", 32'(stall), 1);
    rst = 0;
    #1;
    check("rb_rst_req", 32'(mem_req), 0);
    check("rb_rst_stall", 32'(stall), 0);
    check("rb_rst_we", 32'(mem_we), 0);
    check("rb_rst_wb_valid", 32'(wb_valid), 0);
    tick();
    clr();
    rst = 1;
    mem_ready = 1; mem_rdata = 16'hDEAD;
    repeat (3) tick();
    check("rb_no_wb_valid", 32'(wb_valid), 0);
    check("rb_no_wb_we", 32'(wb_we), 0);
    check("rb_idle_ready_req", 32'(mem_req), 0);

    // zero-wait load
    load_in(4'd3, 16'h0040);
    mem_ready = 1; mem_rdata = 16'hBEEF;
    #4;
    check("zw_req", 32'(mem_req), 1);
    check("zw_addr", 32'(mem_addr), 32'h0040);
    check("zw_we", 32'(mem_we), 0);
    check("zw_stall", 32'(stall), 0);
    tick();
    check("zw_wb_valid", 32'(wb_valid), 1);
    check("zw_wb_we", 32'(wb_we), 1);
    check("zw_wb_rd", 32'(wb_rd), 3);
    check("zw_wb_data", 32'(wb_data), 32'hBEEF);

    // 3-cycle store, in_* disturbed while busy
    clr();
    in_valid = 1; in_memwrite = 1; in_writereg = 1; in_rd = 4'd6;
    in_alu = 16'h0100; in_wdata = 16'h1234;
    #4;
    check("st1_req", 32'(mem_req), 1);
    check("st1_we", 32'(mem_we), 1);
    check("st1_stall", 32'(stall), 1);
    tick();
    check("st1_bubble", 32'(wb_valid), 0);
    in_alu = 16'hFFFF; in_wdata = 16'h0000; in_memwrite = 0; in_memread = 1;
    #4;
    check("st2_addr", 32'(mem_addr), 32'h0100);
    check("st2_wdata", 32'(mem_wdata), 32'h1234);
    check("st2_we", 32'(mem_we), 1);
    check("st2_stall", 32'(stall), 1);
    tick();
    check("st2_bubble", 32'(wb_valid), 0);
    mem_ready = 1;
    #4;
    check("st3_stall", 32'(stall), 0);
    check("st3_addr", 32'(mem_addr), 32'h0100);
    check("st3_wdata", 32'(mem_wdata), 32'h1234);
    tick();
    check("st_wb_valid", 32'(wb_valid), 1);
    check("st_wb_we", 32'(wb_we), 0);
    clr();
    #4;
    check("st_no_dup_req", 32'(mem_req), 0);
    tick();

    // load (ready on 2nd cycle) then ALU op
    load_in(4'd9, 16'h0200);
    #4;
    check("la_stall", 32'(stall), 1);
    tick();
    check("la_bubble_valid", 32'(wb_valid), 0);
    check("la_bubble_we", 32'(wb_we), 0);
    mem_ready = 1; mem_rdata = 16'h5A5A;
    #4;
    check("la_ready_stall", 32'(stall), 0);
    tick();
    check("la_wb_we", 32'(wb_we), 1);
    check("la_wb_rd", 32'(wb_rd), 9);
    check("la_wb_data", 32'(wb_data), 32'h5A5A);
    clr();
    in_valid = 1; in_writereg = 1; in_rd = 4'd5; in_alu = 16'h0007;
    #4;
    check("alu_req", 32'(mem_req), 0);
    tick();
    check("alu_wb_we", 32'(wb_we), 1);
    check("alu_wb_rd", 32'(wb_rd), 5);
    check("alu_wb_data", 32'(wb_data), 32'h0007);
    clr();
    tick();
    check("alu_single_pulse", 32'(wb_we), 0);
    check("alu_after_valid", 32'(wb_valid), 0);

    // link, R0, memtoreg-over-pcs priority
    clr();
    in_valid = 1; in_pcs = 1; in_writereg = 1; in_rd = 4'd15; in_pc = 16'h0022; in_alu = 16'h0099;
    tick();
    check("link_data", 32'(wb_data), 32'h0022);
    check("link_we", 32'(wb_we), 1);
    check("link_rd", 32'(wb_rd), 15);
    clr();
    in_valid = 1; in_writereg = 1; in_rd = 4'd0; in_alu = 16'h0055;
    tick();
    check("r0_valid", 32'(wb_valid), 1);
    check("r0_we", 32'(wb_we), 0);
    check("r0_data", 32'(wb_data), 32'h0055);
    load_in(4'd4, 16'h0010);
    in_pcs = 1; in_pc = 16'h0033; mem_ready = 1; mem_rdata = 16'h0ABC;
    tick();
    check("prio_data", 32'(wb_data), 32'h0ABC);

    // timeout
    load_in(4'd7, 16'h0300);
    stall_cnt = 0;
    aborted = 0;
    for (int i = 0; i < 40; i++) begin
      #4;
      if (!stall) begin
        aborted = 1;
        break;
      end
      stall_cnt++;
      tick();
    end
    check("to_aborted", 32'(aborted), 1);
    check("to_stall_cycles", 32'(stall_cnt), 15);
    check("to_err_before", 32'(mem_err), 0);
    tick();
    check("to_mem_err", 32'(mem_err), 1);
    check("to_wb_valid", 32'(wb_valid), 1);
    check("to_wb_we", 32'(wb_we), 0);
    clr();
    #4;
    check("to_idle_req", 32'(mem_req), 0);
    tick();

    // halt
    clr();
    in_valid = 1; in_hlt = 1;
    tick();
    check("hlt_wb_hlt", 32'(wb_hlt), 1);
    check("hlt_halted", 32'(halted), 1);
    check("hlt_wb_valid", 32'(wb_valid), 1);
    load_in(4'd8, 16'h0400);
    #4;
    check("hlt_no_req", 32'(mem_req), 0);
    check("hlt_no_stall", 32'(stall), 0);
    tick();
    check("hlt_bubble", 32'(wb_valid), 0);
    check("hlt_pulse_end", 32'(wb_hlt), 0);
    check("hlt_sticky", 32'(halted), 1);
    check("err_sticky", 32'(mem_err), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
